// File: rtl/step_tick_gen.sv
// step_tick_gen: power-of-two tick enable with debounced run/pause and
// single-step pushbuttons. Downstream logic runs on clk and advances on tick.
module step_tick_gen #(
  parameter int CNT_W      = 26,
  parameter int SEL_W      = 5,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] div_sel,
  input  logic             run_key,
  input  logic             step_key,
  output logic             tick,
  output logic             running,
  output logic             run_db,
  output logic             step_db
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    STEP  = 2'd2
  } state_t;

  // Key index 0 is run_key, index 1 is step_key.
  logic [1:0]       key_p1;
  logic [1:0]       key_p2;
  logic [1:0]       db;
  logic [1:0]       db_d;
  logic [DEB_W-1:0] deb_cnt [2];
  logic [1:0]       press;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mask;
  state_t           state;
  state_t           next_state;

  assign run_db  = db[0];
  assign step_db = db[1];

  // A press is the cycle after the debounced level falls; releases are ignored.
  assign press = db_d & ~db;

  // Two-flop synchroniser and stable-count debouncer for both keys.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_p1 <= 2'b11;
      key_p2 <= 2'b11;
      db     <= 2'b11;
      db_d   <= 2'b11;
      for (int k = 0; k < 2; k++) begin
        deb_cnt[k] <= '0;
      end
    end else begin
      key_p1 <= {step_key, run_key};
      key_p2 <= key_p1;
      db_d   <= db;
      for (int k = 0; k < 2; k++) begin
        if (key_p2[k] == db[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          db[k]      <= key_p2[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Low eff_sel bits set, where eff_sel = min(div_sel, CNT_W); clamping falls out of the loop bound.
  always_comb begin
    mask = '0;
    for (int i = 0; i < CNT_W; i++) begin
      mask[i] = (i < int'(div_sel));
    end
  end

  // Next-state logic: run press beats step press; presses during STEP are dropped.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (press[0]) next_state = PAUSE;
      end
      PAUSE: begin
        if (press[0])      next_state = RUN;
        else if (press[1]) next_state = STEP;
      end
      STEP: begin
        next_state = PAUSE;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // State register with running registered alongside it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      running <= 1'b1;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
    end
  end

  // Divider and tick register, keyed on the state being entered so the
  // pausing edge already holds cnt and clears tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      case (next_state)
        RUN: begin
          cnt  <= cnt + 1'b1;
          tick <= ((cnt & mask) == mask);
        end
        STEP: begin
          tick <= 1'b1;
        end
        default: begin
          tick <= 1'b0;
        end
      endcase
    end
  end

endmodule
